// File: rtl/vec_dot_sqrt_seq_if.sv
// Operand/result handshake bundle for vec_dot_sqrt_seq; master drives operands, slave computes.
interface vec_dot_sqrt_seq_if #(
  parameter int W     = 16,
  parameter int NCOMP = 3
);
  localparam int ACC_W = 2 * W + $clog2(NCOMP);
  localparam int RES_W = (ACC_W + 1) / 2;

  logic                    in_valid;
  logic                    in_ready;
  logic [NCOMP*W-1:0]      a_flat;
  logic [NCOMP*W-1:0]      b_flat;
  logic                    out_valid;
  logic                    out_ready;
  logic [RES_W-1:0]        res;
  logic signed [ACC_W-1:0] dot;
  logic                    neg;

  modport master (
    output in_valid, a_flat, b_flat, out_ready,
    input  in_ready, out_valid, res, dot, neg
  );

  modport slave (
    input  in_valid, a_flat, b_flat, out_ready,
    output in_ready, out_valid, res, dot, neg
  );
endinterface

// File: rtl/vec_dot_sqrt_seq.sv
// Sequential sqrt(sum a_i*b_i): one shared MAC, then a restoring bit-serial integer root.
// Define VEC_DOT_SQRT_ROUND_EN to round the root to nearest (saturating) instead of flooring.
module vec_dot_sqrt_seq #(
  parameter int W     = 16,
  parameter int NCOMP = 3
) (
  input logic                CLK2,
  input logic                RST,
  vec_dot_sqrt_seq_if.slave  io_bus
);
  localparam int ACC_W   = 2 * W + $clog2(NCOMP);
  localparam int RES_W   = (ACC_W + 1) / 2;
  localparam int REM_W   = RES_W + 2;
  localparam int CNT_MAX = (RES_W > NCOMP) ? RES_W : NCOMP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_SQRT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]              r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [NCOMP*W-1:0]      r_a;
  logic [NCOMP*W-1:0]      r_b;
  logic signed [ACC_W-1:0] r_acc;
  logic [2*RES_W-1:0]      r_rad;
  logic [REM_W-1:0]        r_rem;
  logic [RES_W-1:0]        r_root;
  logic [RES_W-1:0]        r_res;
  logic signed [ACC_W-1:0] r_dot;
  logic                    r_neg;

  logic signed [2*W-1:0]   w_prod;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic [2*RES_W-1:0]      w_rad_ld;
  logic [REM_W+1:0]        w_rem_sh;
  logic [REM_W+1:0]        w_trial;
  logic [REM_W+1:0]        w_rem_step;
  logic                    w_ge;
  logic [RES_W-1:0]        w_root_nxt;
  logic [RES_W-1:0]        w_res_fin;
  logic                    w_mac_last;
  logic                    w_sqrt_last;
  logic                    w_unused;

  always_comb begin
    // Operands are shifted down each MAC cycle, so component k is always in the low W bits.
    w_prod     = $signed(r_a[W-1:0]) * $signed(r_b[W-1:0]);
    w_acc_nxt  = r_acc + ACC_W'(w_prod);
    w_rad_ld   = w_acc_nxt[ACC_W-1] ? '0 : (2 * RES_W)'($unsigned(w_acc_nxt));
    w_rem_sh   = {r_rem, r_rad[2*RES_W-1 -: 2]};
    w_trial    = (REM_W + 2)'({r_root, 2'b01});
    w_ge       = (w_rem_sh >= w_trial);
    w_rem_step = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
    w_root_nxt = (r_root << 1) | RES_W'(w_ge);
    w_res_fin  = w_root_nxt;
`ifdef VEC_DOT_SQRT_ROUND_EN
    // rem > root means radicand > root^2 + root, i.e. above the midpoint to root+1.
    if ((w_rem_step > (REM_W + 2)'(w_root_nxt)) && (w_root_nxt != '1)) begin
      w_res_fin = w_root_nxt + RES_W'(1);
    end
`endif
    w_mac_last  = (r_cnt == CNT_W'(NCOMP - 1));
    w_sqrt_last = (r_cnt == CNT_W'(RES_W - 1));
    w_unused    = ^w_rem_step[REM_W+1:REM_W];
  end

  always_ff @(posedge CLK2 or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_rad   <= '0;
      r_rem   <= '0;
      r_root  <= '0;
      r_res   <= '0;
      r_dot   <= '0;
      r_neg   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_bus.in_valid) begin
            r_a     <= io_bus.a_flat;
            r_b     <= io_bus.b_flat;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= ST_MAC;
          end
        end
        ST_MAC: begin
          r_acc <= w_acc_nxt;
          r_a   <= r_a >> W;
          r_b   <= r_b >> W;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_mac_last) begin
            r_rad   <= w_rad_ld;
            r_rem   <= '0;
            r_root  <= '0;
            r_cnt   <= '0;
            r_state <= ST_SQRT;
          end
        end
        ST_SQRT: begin
          r_rem  <= w_rem_step[REM_W-1:0];
          r_root <= w_root_nxt;
          r_rad  <= r_rad << 2;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (w_sqrt_last) begin
            r_res   <= w_res_fin;
            r_dot   <= r_acc;
            r_neg   <= r_acc[ACC_W-1];
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (io_bus.out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Gated by RST so in_ready is low while reset is held.
  assign io_bus.in_ready  = (r_state == ST_IDLE) & RST;
  assign io_bus.out_valid = (r_state == ST_DONE);
  assign io_bus.res       = r_res;
  assign io_bus.dot       = r_dot;
  assign io_bus.neg       = r_neg;
endmodule

// File: tb/tb_vec_dot_sqrt_seq.sv
// Scoreboard bench for vec_dot_sqrt_seq (W=16, NCOMP=3): directed vectors, decoupled monitor.
module tb_vec_dot_sqrt_seq;
  localparam int W     = 16;
  localparam int NCOMP = 3;
  localparam int LAT   = 21;
`ifdef VEC_DOT_SQRT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  typedef struct {
    logic signed [33:0] dot;
    logic [16:0]        res;
    logic               neg;
  } exp_t;

  logic CLK2 = 1'b0;
  logic RST  = 1'b0;
  int   cyc  = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  int   lat_q[$];
  logic prev_ov = 1'b0;

  vec_dot_sqrt_seq_if #(.W(W), .NCOMP(NCOMP)) bus ();

  vec_dot_sqrt_seq #(.W(W), .NCOMP(NCOMP)) dut (
    .CLK2   (CLK2),
    .RST    (RST),
    .io_bus (bus)
  );

  always #5 CLK2 = ~CLK2;
  always @(posedge CLK2) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [47:0] pack(input int x0, input int x1, input int x2);
    pack = {x2[15:0], x1[15:0], x0[15:0]};
  endfunction

  // Monitor: latency on rising out_valid, data on each accepted result.
  always @(negedge CLK2) begin
    if (!RST) begin
      exp_q.delete();
      lat_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (bus.out_valid && !prev_ov) begin
        if (lat_q.size() == 0) chk("spurious_out_valid", 64'd1, 64'd0);
        else chk("latency", 64'(cyc - lat_q.pop_front()), 64'(LAT));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("dot", 64'(bus.dot), 64'(e.dot));
          chk("res", 64'(bus.res), 64'(e.res));
          chk("neg", 64'(bus.neg), 64'(e.neg));
        end
      end
      prev_ov = bus.out_valid;
    end
  end

  task automatic send(input logic [47:0] a, input logic [47:0] b,
                      input logic signed [33:0] edot, input logic [16:0] eres, input logic eneg);
    int   n = 0;
    exp_t e;
    @(negedge CLK2);
    bus.in_valid = 1'b1;
    bus.a_flat   = a;
    bus.b_flat   = b;
    while (!bus.in_ready && n < 200) begin
      @(negedge CLK2);
      n++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 64'd1, 64'd0);
    end else begin
      e.dot = edot;
      e.res = eres;
      e.neg = eneg;
      exp_q.push_back(e);
      lat_q.push_back(cyc);
    end
    @(negedge CLK2);
    // Scramble operands after accept; they must not affect the result.
    bus.in_valid = 1'b0;
    bus.a_flat   = '1;
    bus.b_flat   = 48'h8000_7fff_1234;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge CLK2);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ov_cnt;
    int n;
    bus.in_valid  = 1'b0;
    bus.a_flat    = '0;
    bus.b_flat    = '0;
    bus.out_ready = 1'b1;

    #12;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge CLK2);
    RST = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("post_rst_res", 64'(bus.res), 64'd0);
    chk("post_rst_dot", 64'(bus.dot), 64'd0);
    chk("post_rst_neg", 64'(bus.neg), 64'd0);

    send(pack(3, 4, 0), pack(3, 4, 0), 34'sd25, 17'd5, 1'b0);
    send(pack(-2, 0, 0), pack(3, 0, 0), -34'sd6, 17'd0, 1'b1);
    send(pack(-32768, -32768, -32768), pack(-32768, -32768, -32768),
         34'sd3221225472, RND ? 17'd56756 : 17'd56755, 1'b0);
    send(pack(5, 1, 2), pack(5, 1, 2), 34'sd30, 17'd5, 1'b0);
    send(pack(5, 1, 2), pack(5, 2, 3), 34'sd33, RND ? 17'd6 : 17'd5, 1'b0);
    send(pack(1, 0, 0), pack(1, 0, 0), 34'sd1, 17'd1, 1'b0);
    send(pack(0, 0, 7), pack(0, 0, 7), 34'sd49, 17'd7, 1'b0);
    drain();

    // Backpressure: hold the result for 10 cycles.
    bus.out_ready = 1'b0;
    send(pack(6, 8, 0), pack(6, 8, 0), 34'sd100, 17'd10, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge CLK2);
      n++;
    end
    chk("hold_out_valid_seen", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK2);
      chk("hold_res", 64'(bus.res), 64'd10);
      chk("hold_dot", 64'(bus.dot), 64'd100);
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge CLK2);
    #1 bus.out_ready = 1'b1;
    @(negedge CLK2);
    @(negedge CLK2);
    chk("release_in_ready", 64'(bus.in_ready), 64'd1);
    chk("release_out_valid", 64'(bus.out_valid), 64'd0);
    drain();

    // Reset in the middle of SQRT discards the work.
    send(pack(3, 4, 0), pack(3, 4, 0), 34'sd25, 17'd5, 1'b0);
    repeat (8) @(negedge CLK2);
    RST = 1'b0;
    #1;
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_res", 64'(bus.res), 64'd0);
    chk("abort_dot", 64'(bus.dot), 64'd0);
    chk("abort_neg", 64'(bus.neg), 64'd0);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
    repeat (2) @(negedge CLK2);
    RST = 1'b1;
    #1;
    chk("abort_release_in_ready", 64'(bus.in_ready), 64'd1);
    ov_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK2);
      if (bus.out_valid) ov_cnt++;
    end
    chk("no_stale_output", 64'(ov_cnt), 64'd0);

    send(pack(1, 2, 3), pack(4, 5, 6), 34'sd32, RND ? 17'd6 : 17'd5, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
